// File: rtl/uart_tx_dev_if.sv
// uart_tx_dev_if: device-side bus between the bridge and a memory-mapped
// peripheral.
//   Addr  - device address; the peripheral decodes only Addr[3:2]
//   We    - write enable for this device
//   WData - write data
//   RData - read data, driven combinationally by the peripheral
//   IntRq - interrupt request from the peripheral to the bridge
// The bridge side uses the master modport. The peripheral side uses the slave modport.
interface uart_tx_dev_if;
  logic [31:0] Addr;
  logic        We;
  logic [31:0] WData;
  logic [31:0] RData;
  logic        IntRq;

  modport master (output Addr, output We, output WData, input RData, input IntRq);
  modport slave  (input Addr, input We, input WData, output RData, output IntRq);
endinterface

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: memory-mapped 8N1 UART transmitter.
// A DATA write while idle with EN set sends one frame on TxD. The frame is a
// start bit, then 8 data bits LSB first, then a stop bit. Each bit lasts D
// clocks, where D is the divisor captured at the start of the frame (0 acts
// as 1). DONE is set when the frame completes, and IntRq = DONE & IM.
//   Clk   - system clock, rising edge
//   Reset - synchronous, active-high reset
//   bus   - device bus (Addr/We/WData in; RData/IntRq out)
//   TxD   - registered serial output, idle high
// Register map, selected by Addr[3:2]:
//   0 DATA   - [7:0] last byte
//   1 CTRL   - bit0 IM, bit1 EN
//   2 DIV    - [DIV_W-1:0] clocks per bit
//   3 STATUS - bit0 BUSY, bit1 DONE; a write clears DONE
module uart_tx_dev #(
  parameter int DIV_RESET = 16,
  parameter int DIV_W     = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  uart_tx_dev_if.slave  bus,
  output logic          TxD
);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BITS = 2'd2, STOP = 2'd3} state_t;

  state_t             state, state_nx;
  logic [7:0]         data, shift, shift_nx;
  logic               im, en, done, done_nx, txd, txd_nx;
  logic [DIV_W-1:0]   div, frame_div, frame_div_nx, baud_cnt, baud_cnt_nx, bit_last;
  logic [2:0]         bit_cnt, bit_cnt_nx;
  logic [1:0]         sel;
  logic               data_wr, ctrl_wr, div_wr, status_wr, start_frame, bit_end, busy;
  logic [31:0]        div_ext;

  assign sel         = bus.Addr[3:2];
  assign data_wr     = bus.We && (sel == 2'd0);
  assign ctrl_wr     = bus.We && (sel == 2'd1);
  assign div_wr      = bus.We && (sel == 2'd2);
  assign status_wr   = bus.We && (sel == 2'd3);
  assign busy        = (state != IDLE);
  assign start_frame = data_wr && en && !busy;
  // A zero divisor behaves like 1, so the last count value is 0 in both cases.
  assign bit_last    = (frame_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : frame_div - {{(DIV_W-1){1'b0}}, 1'b1};
  assign bit_end     = (baud_cnt == bit_last);

  // Software-visible registers: DATA, CTRL and DIV.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      data <= 8'd0;
      im   <= 1'b0;
      en   <= 1'b0;
      div  <= DIV_W'(DIV_RESET);
    end else begin
      // DATA writes during a frame are dropped entirely.
      if (data_wr && !busy) data <= bus.WData[7:0];
      if (ctrl_wr) begin
        im <= bus.WData[0];
        en <= bus.WData[1];
      end
      if (div_wr) div <= bus.WData[DIV_W-1:0];
    end
  end

  // Frame state: FSM, shifter, counters, DONE flag and the registered TxD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      shift     <= 8'd0;
      bit_cnt   <= 3'd0;
      baud_cnt  <= {DIV_W{1'b0}};
      frame_div <= {DIV_W{1'b0}};
      done      <= 1'b0;
      txd       <= 1'b1;
    end else begin
      state     <= state_nx;
      shift     <= shift_nx;
      bit_cnt   <= bit_cnt_nx;
      baud_cnt  <= baud_cnt_nx;
      frame_div <= frame_div_nx;
      done      <= done_nx;
      txd       <= txd_nx;
    end
  end

  // Next-state logic. TxD is computed from the next state, so the line
  // changes on the same edge as the state change.
  always_comb begin
    state_nx     = state;
    shift_nx     = shift;
    bit_cnt_nx   = bit_cnt;
    baud_cnt_nx  = baud_cnt;
    frame_div_nx = frame_div;
    txd_nx       = txd;
    // A STATUS write clears DONE. Completion below overrides this, so set wins.
    if (status_wr) done_nx = 1'b0;
    else           done_nx = done;

    case (state)
      IDLE: begin
        txd_nx      = 1'b1;
        bit_cnt_nx  = 3'd0;
        baud_cnt_nx = {DIV_W{1'b0}};
        if (start_frame) begin
          state_nx     = START;
          shift_nx     = bus.WData[7:0];
          frame_div_nx = div;
          txd_nx       = 1'b0;
          done_nx      = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_nx    = BITS;
          baud_cnt_nx = {DIV_W{1'b0}};
          txd_nx      = shift[0];
        end else begin
          baud_cnt_nx = baud_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      BITS: begin
        if (bit_end) begin
          baud_cnt_nx = {DIV_W{1'b0}};
          if (bit_cnt == 3'd7) begin
            state_nx   = STOP;
            bit_cnt_nx = 3'd0;
            txd_nx     = 1'b1;
          end else begin
            shift_nx   = {1'b0, shift[7:1]};
            bit_cnt_nx = bit_cnt + 3'd1;
            txd_nx     = shift[1];
          end
        end else begin
          baud_cnt_nx = baud_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nx    = IDLE;
          baud_cnt_nx = {DIV_W{1'b0}};
          txd_nx      = 1'b1;
          done_nx     = 1'b1;
        end else begin
          baud_cnt_nx = baud_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx    = IDLE;
        baud_cnt_nx = {DIV_W{1'b0}};
        bit_cnt_nx  = 3'd0;
        txd_nx      = 1'b1;
      end
    endcase
  end

  // Read mux, selected by the decoded address.
  always_comb begin
    div_ext              = 32'd0;
    div_ext[DIV_W-1:0]   = div;
    case (sel)
      2'd0:    bus.RData = {24'd0, data};
      2'd1:    bus.RData = {30'd0, en, im};
      2'd2:    bus.RData = div_ext;
      2'd3:    bus.RData = {30'd0, done, busy};
      default: bus.RData = 32'd0;
    endcase
  end

  assign bus.IntRq = done & im;
  assign TxD       = txd;

endmodule
